pc_ir_sp_unit: RTL and testbench



---
 rtl/pc_ir_sp_unit.sv | 273 +++++++++++++++++++++++++++
 tb/tb_pc_ir_sp_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ir_sp_unit.sv
// -----------------------------------------------------------------------------
// pc_ir_sp_unit
//
// Purpose:
//   Datapath slice that owns the program counter (PC), instruction register
//   (IR) and stack pointer (SP). It sequences instruction fetch, jump, push
//   and pop requests from the control FSM through one shared memory port
//   that may take any number of cycles to respond.
//
// Optional feature:
//   PCSP_BOUNDS_CHECK_EN - when defined, a push at SP==SP_LIMIT and a pop at
//   SP==SP_INIT are refused (no memory access, Err+Done pulse, sticky
//   Overflow/Underflow). When undefined, push/pop always access memory, SP
//   wraps modulo 2^AW and Overflow/Underflow/Err are tied to 0.
//
// Ports:
//   CLK        in   1    clock, rising edge
//   RESET      in   1    asynchronous active-high reset
//   Fetch      in   1    start instruction fetch (IDLE only)
//   Jump       in   1    load PC from JumpAddr (IDLE only, single cycle)
//   JumpAddr   in   AW   jump target
//   Push       in   1    push PushData
//   PushData   in   DW   data to push (latched when the push is accepted)
//   Pop        in   1    pop top of stack into PopData
//   PC         out  AW   program counter
//   SP         out  AW   stack pointer
//   IR         out  DW   instruction register
//   Op         out  4    IR[DW-1:DW-4]
//   PopData    out  DW   last popped value
//   Busy       out  1    high while not in IDLE
//   Done       out  1    one-cycle pulse when an operation completes
//   Err        out  1    one-cycle pulse with Done when push/pop was refused
//   Overflow   out  1    sticky: push refused at SP_LIMIT
//   Underflow  out  1    sticky: pop refused at SP_INIT
//   MemReq     out  1    memory request
//   MemWrite   out  1    write qualifier for MemReq
//   MemAddr    out  AW   memory address
//   MemWData   out  DW   memory write data
//   MemRData   in   DW   memory read data, valid with MemAck
//   MemAck     in   1    one-cycle completion from memory
//   DbgState   out  2    current FSM state (0 IDLE, 1 FETCH, 2 PUSH, 3 POP)
//
// Memory handshake:
//   MemReq/MemWrite/MemAddr/MemWData are registered. Once MemReq rises they
//   are held stable until the cycle in which MemAck is sampled high; that
//   edge completes the transfer and MemReq falls. MemAck may already be high
//   in the first cycle MemReq is high. MemAck while MemReq is low is ignored.
// -----------------------------------------------------------------------------
module pc_ir_sp_unit #(
    parameter int            DW       = 16,
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [AW-1:0] SP_INIT  = AW'(16'hFFFE),
    parameter logic [AW-1:0] SP_LIMIT = AW'(16'hFF00),
    parameter int            STEP     = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          Fetch,
    input  logic          Jump,
    input  logic [AW-1:0] JumpAddr,
    input  logic          Push,
    input  logic [DW-1:0] PushData,
    input  logic          Pop,
    output logic [AW-1:0] PC,
    output logic [AW-1:0] SP,
    output logic [DW-1:0] IR,
    output logic [3:0]    Op,
    output logic [DW-1:0] PopData,
    output logic          Busy,
    output logic          Done,
    output logic          Err,
    output logic          Overflow,
    output logic          Underflow,
    output logic          MemReq,
    output logic          MemWrite,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    input  logic          MemAck,
    output logic [1:0]    DbgState
);

`ifdef PCSP_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    localparam logic [AW-1:0] STEP_A = AW'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PUSH  = 2'd2,
        ST_POP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] sp_q, sp_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] popdata_q, popdata_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          memreq_q, memreq_d;
    logic          memwrite_q, memwrite_d;
    logic [AW-1:0] memaddr_q, memaddr_d;
    logic [DW-1:0] memwdata_q, memwdata_d;

    // Refusal conditions; constant 0 when bounds checking is compiled out.
    logic push_refuse;
    logic pop_refuse;
    // A transfer completes only when the memory acknowledges a live request.
    logic mem_done;

    assign push_refuse = BOUNDS_EN & (sp_q == SP_LIMIT);
    assign pop_refuse  = BOUNDS_EN & (sp_q == SP_INIT);
    assign mem_done    = memreq_q & MemAck;

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        sp_d       = sp_q;
        ir_d       = ir_q;
        popdata_d  = popdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        memreq_d   = memreq_q;
        memwrite_d = memwrite_q;
        memaddr_d  = memaddr_q;
        memwdata_d = memwdata_q;

        case (state_q)
            ST_IDLE: begin
                // Priority Jump > Pop > Push > Fetch; losers are dropped.
                if (Jump) begin
                    pc_d   = JumpAddr;
                    done_d = 1'b1;
                end else if (Pop) begin
                    if (pop_refuse) begin
                        unf_d  = 1'b1;
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_POP;
                        memreq_d   = 1'b1;
                        memwrite_d = 1'b0;
                        memaddr_d  = sp_q;
                    end
                end else if (Push) begin
                    if (push_refuse) begin
                        ovf_d  = 1'b1;
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        // Pre-decrement: write goes below the current SP.
                        state_d    = ST_PUSH;
                        memreq_d   = 1'b1;
                        memwrite_d = 1'b1;
                        memaddr_d  = sp_q - STEP_A;
                        memwdata_d = PushData;
                    end
                end else if (Fetch) begin
                    state_d    = ST_FETCH;
                    memreq_d   = 1'b1;
                    memwrite_d = 1'b0;
                    memaddr_d  = pc_q;
                end
            end

            ST_FETCH: begin
                if (mem_done) begin
                    ir_d       = MemRData;
                    pc_d       = pc_q + STEP_A;
                    memreq_d   = 1'b0;
                    memwrite_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            ST_PUSH: begin
                if (mem_done) begin
                    sp_d       = sp_q - STEP_A;
                    memreq_d   = 1'b0;
                    memwrite_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            ST_POP: begin
                if (mem_done) begin
                    // Post-increment: read at SP, then release the slot.
                    popdata_d  = MemRData;
                    sp_d       = sp_q + STEP_A;
                    memreq_d   = 1'b0;
                    memwrite_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                memreq_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            sp_q       <= SP_INIT;
            ir_q       <= '0;
            popdata_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            memreq_q   <= 1'b0;
            memwrite_q <= 1'b0;
            memaddr_q  <= '0;
            memwdata_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            ir_q       <= ir_d;
            popdata_q  <= popdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            memreq_q   <= memreq_d;
            memwrite_q <= memwrite_d;
            memaddr_q  <= memaddr_d;
            memwdata_q <= memwdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign PC        = pc_q;
    assign SP        = sp_q;
    assign IR        = ir_q;
    assign Op        = ir_q[DW-1:DW-4];
    assign PopData   = popdata_q;
    assign Busy      = (state_q != ST_IDLE);
    assign Done      = done_q;
    assign Err       = BOUNDS_EN & err_q;
    assign Overflow  = BOUNDS_EN & ovf_q;
    assign Underflow = BOUNDS_EN & unf_q;
    assign MemReq    = memreq_q;
    assign MemWrite  = memwrite_q;
    assign MemAddr   = memaddr_q;
    assign MemWData  = memwdata_q;
    assign DbgState  = state_q;

endmodule

// File: tb/tb_pc_ir_sp_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_ir_sp_unit
//
// Directed steps followed by randomized operations on pc_ir_sp_unit
// (RESET_PC = 0x0010). A behavioural model tracks PC/SP/IR/PopData and the
// sticky flags, and owns a sparse memory image; expected memory transfers are
// queued in exp_q when an operation is issued and compared when the DUT
// presents its request.
// -----------------------------------------------------------------------------
module tb_pc_ir_sp_unit;

    localparam int          DW        = 16;
    localparam int          AW        = 16;
    localparam logic [15:0] RST_PC    = 16'h0010;
    localparam logic [15:0] SP_INIT_V = 16'hFFFE;
    localparam logic [15:0] SP_LIM_V  = 16'hFF00;

`ifdef PCSP_BOUNDS_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam int K_NONE  = 0;
    localparam int K_JUMP  = 1;
    localparam int K_POP   = 2;
    localparam int K_PUSH  = 3;
    localparam int K_FETCH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          fetch, jump, push, pop;
    logic [AW-1:0] jump_addr;
    logic [DW-1:0] push_data;
    logic [AW-1:0] pc, sp, mem_addr;
    logic [DW-1:0] ir, pop_data, mem_wdata, mem_rdata;
    logic [3:0]    op;
    logic          busy, done, err, overflow, underflow;
    logic          mem_req, mem_write, mem_ack;
    logic [1:0]    dbg_state;

    pc_ir_sp_unit #(
        .DW(DW), .AW(AW), .RESET_PC(RST_PC),
        .SP_INIT(SP_INIT_V), .SP_LIMIT(SP_LIM_V), .STEP(2)
    ) dut (
        .CLK(clk), .RESET(rst),
        .Fetch(fetch), .Jump(jump), .JumpAddr(jump_addr),
        .Push(push), .PushData(push_data), .Pop(pop),
        .PC(pc), .SP(sp), .IR(ir), .Op(op), .PopData(pop_data),
        .Busy(busy), .Done(done), .Err(err),
        .Overflow(overflow), .Underflow(underflow),
        .MemReq(mem_req), .MemWrite(mem_write), .MemAddr(mem_addr),
        .MemWData(mem_wdata), .MemRData(mem_rdata), .MemAck(mem_ack),
        .DbgState(dbg_state)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [15:0] m_pc, m_sp, m_ir, m_pd;
    logic        m_ovf, m_unf;
    logic [15:0] mem_m [logic [15:0]];
    logic [32:0] exp_q [$];   // {write, addr, wdata}

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc  = RST_PC;
        m_sp  = SP_INIT_V;
        m_ir  = '0;
        m_pd  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".pc"},  pc,        m_pc);
        chk({tag, ".sp"},  sp,        m_sp);
        chk({tag, ".ir"},  ir,        m_ir);
        chk({tag, ".op"},  op,        m_ir >> 12);
        chk({tag, ".pd"},  pop_data,  m_pd);
        chk({tag, ".ovf"}, overflow,  m_ovf);
        chk({tag, ".unf"}, underflow, m_unf);
    endtask

    task automatic clear_strobes();
        fetch = 1'b0;
        jump  = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    // ---------------- driver ----------------
    // strb = {Jump, Pop, Push, Fetch}; called 1 ns after a rising edge.
    task automatic do_op(input logic [3:0] strb, input logic [15:0] jaddr,
                         input logic [15:0] pdata, input int waits,
                         input bit use_force, input logic [15:0] force_data);
        int          kind;
        bit          refused;
        bit          mem_op;
        logic [15:0] rd;
        logic [32:0] tr;
        if (strb[3])      kind = K_JUMP;
        else if (strb[2]) kind = K_POP;
        else if (strb[1]) kind = K_PUSH;
        else if (strb[0]) kind = K_FETCH;
        else              kind = K_NONE;
        refused = CHK && ((kind == K_POP  && m_sp == SP_INIT_V) ||
                          (kind == K_PUSH && m_sp == SP_LIM_V));
        mem_op  = (kind == K_POP || kind == K_PUSH || kind == K_FETCH) && !refused;
        if (mem_op) begin
            if (kind == K_FETCH)     exp_q.push_back({1'b0, m_pc, 16'h0000});
            else if (kind == K_PUSH) exp_q.push_back({1'b1, m_sp - 16'd2, pdata});
            else                     exp_q.push_back({1'b0, m_sp, 16'h0000});
        end

        jump      = strb[3];
        pop       = strb[2];
        push      = strb[1];
        fetch     = strb[0];
        jump_addr = jaddr;
        push_data = pdata;
        tick();
        clear_strobes();
        // Scramble the operands so a missing latch would be visible.
        jump_addr = 16'($urandom);
        push_data = 16'($urandom);

        if (mem_op) begin
            tr = exp_q.pop_front();
            chk("req_rise", mem_req, 1'b1);
            chk("req_we",   mem_write, tr[32]);
            chk("req_addr", mem_addr, tr[31:16]);
            if (tr[32]) chk("req_wdata", mem_wdata, tr[15:0]);
            chk("busy_hi",  busy, 1'b1);
            chk("done_lo",  done, 1'b0);
            rd = 16'($urandom);
            if (!tr[32]) begin
                if (use_force)                 rd = force_data;
                else if (mem_m.exists(tr[31:16])) rd = mem_m[tr[31:16]];
                mem_m[tr[31:16]] = rd;
            end
            for (int w = 0; w < waits; w++) begin
                // Strobes while busy must be ignored.
                fetch     = 1'($urandom_range(0, 1));
                jump      = 1'($urandom_range(0, 1));
                push      = 1'($urandom_range(0, 1));
                pop       = 1'($urandom_range(0, 1));
                mem_rdata = 16'($urandom);
                tick();
                chk("wait_req",  mem_req, 1'b1);
                chk("wait_addr", mem_addr, tr[31:16]);
                chk("wait_done", done, 1'b0);
            end
            mem_rdata = rd;
            mem_ack   = 1'b1;
            tick();
            mem_ack = 1'b0;
            clear_strobes();
            if (tr[32]) mem_m[tr[31:16]] = tr[15:0];
            case (kind)
                K_FETCH: begin m_ir = rd; m_pc = m_pc + 16'd2; end
                K_PUSH:  m_sp = m_sp - 16'd2;
                default: begin m_pd = rd; m_sp = m_sp + 16'd2; end
            endcase
            chk("cmp_done", done, 1'b1);
            chk("cmp_err",  err, 1'b0);
            chk("cmp_req",  mem_req, 1'b0);
            chk("cmp_busy", busy, 1'b0);
        end else begin
            if (kind == K_JUMP) m_pc = jaddr;
            if (refused && kind == K_POP)  m_unf = 1'b1;
            if (refused && kind == K_PUSH) m_ovf = 1'b1;
            chk("imm_done", done, kind != K_NONE);
            chk("imm_err",  err, refused);
            chk("imm_req",  mem_req, 1'b0);
            chk("imm_busy", busy, 1'b0);
        end
        chk_regs("op");
    endtask

    // An idle cycle with a stray acknowledge: nothing may change.
    task automatic idle_ack();
        mem_ack   = 1'b1;
        mem_rdata = 16'($urandom);
        tick();
        mem_ack = 1'b0;
        chk("idle_done", done, 1'b0);
        chk("idle_req",  mem_req, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk_regs("idle");
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_req", mem_req, 1'b0);
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        chk_regs("rst");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_strobes();
        jump_addr = '0;
        push_data = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        model_reset();

        // Reset values with MemAck held low.
        repeat (3) tick();
        chk("r_pc",    pc, 16'h0010);
        chk("r_sp",    sp, 16'hFFFE);
        chk("r_ir",    ir, 16'h0000);
        chk("r_req",   mem_req, 1'b0);
        chk("r_we",    mem_write, 1'b0);
        chk("r_addr",  mem_addr, 16'h0000);
        chk("r_wdata", mem_wdata, 16'h0000);
        chk("r_busy",  busy, 1'b0);
        chk("r_done",  done, 1'b0);
        chk("r_err",   err, 1'b0);
        rst = 1'b0;
        tick();
        chk_regs("r");

        // Reset in the middle of a fetch drops MemReq at once.
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        chk("mf_req", mem_req, 1'b1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mf_req_drop", mem_req, 1'b0);
        chk("mf_pc", pc, 16'h0010);
        chk("mf_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        chk_regs("mf");

        // Fetch 0xA123 after 3 wait cycles.
        do_op(4'b0001, 16'h0, 16'h0, 3, 1'b1, 16'hA123);
        chk("f_ir", ir, 16'hA123);
        chk("f_op", op, 4'hA);
        chk("f_pc", pc, 16'h0012);
        tick();
        chk("f_done_pulse", done, 1'b0);

        // Push 0x5555 then pop it back, single-cycle acks.
        do_op(4'b0010, 16'h0, 16'h5555, 0, 1'b0, 16'h0);
        chk("pu_sp", sp, 16'hFFFC);
        do_op(4'b0100, 16'h0, 16'h0, 0, 1'b0, 16'h0);
        chk("po_pd", pop_data, 16'h5555);
        chk("po_sp", sp, 16'hFFFE);

        // Pop at the empty-stack value.
        do_op(4'b0100, 16'h0, 16'h0, 1, 1'b0, 16'h0);
        if (CHK) chk("emp_sp", sp, 16'hFFFE);
        else     chk("emp_sp", sp, 16'h0000);
        chk("emp_unf", underflow, CHK);

        // Jump beats Fetch in the same cycle.
        do_op(4'b1001, 16'h0200, 16'h0, 0, 1'b0, 16'h0);
        chk("j_pc", pc, 16'h0200);

        // Fill the stack down to 0xFF02, then push twice more.
        apply_reset();
        while (m_sp != 16'hFF02) do_op(4'b0010, 16'h0, 16'($urandom), 0, 1'b0, 16'h0);
        do_op(4'b0010, 16'h0, 16'h1234, 0, 1'b0, 16'h0);
        chk("ov_sp1", sp, 16'hFF00);
        do_op(4'b0010, 16'h0, 16'h4321, 0, 1'b0, 16'h0);
        chk("ov_flag", overflow, CHK);
        chk("ov_sp2", sp, CHK ? 16'hFF00 : 16'hFEFE);
        do_op(4'b0100, 16'h0, 16'h0, 2, 1'b0, 16'h0);

        // Randomized operations with mixed strobes and wait states.
        for (int n = 0; n < 250; n++) begin
            do_op(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 3), 1'b0, 16'h0);
            if ($urandom_range(0, 3) == 0) idle_ack();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Watchdog: the sequence above is fixed-length, this only guards a hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
